// File: rtl/tick_stretcher.sv
// Tick-to-level stretcher: each accepted single-cycle tick becomes one lvl pulse of
// HOLD_CYCLES high followed by at least GAP_CYCLES low; ticks arriving mid-pulse are queued.
module tick_stretcher #(
   parameter int HOLD_CYCLES = 4,
   parameter int GAP_CYCLES  = 2,
   parameter int PEND_W      = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              tck,
   output logic              lvl,
   output logic              busy,
   output logic [PEND_W-1:0] pending,
   output logic              overflow
);

   localparam int MAX_CYC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
   localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

   localparam logic [CW-1:0]     HOLD_LOAD = CW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0]     GAP_LOAD  = CW'(GAP_CYCLES - 1);
   localparam logic [PEND_W-1:0] PEND_MAX  = {PEND_W{1'b1}};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HOLD = 2'd1,
      GAP  = 2'd2
   } state_t;

   state_t            state_reg, state_next;
   logic [CW-1:0]     cnt_reg, cnt_next;
   logic [PEND_W-1:0] pend_reg, pend_next;
   logic              ovf_reg, ovf_next;
   logic              lvl_reg;
   logic              push, pop;

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      push       = 1'b0;
      pop        = 1'b0;
      case (state_reg)
         IDLE: begin
            if (tck) begin
               state_next = HOLD;
               cnt_next   = HOLD_LOAD;
            end
         end
         HOLD: begin
            push = tck;
            if (cnt_reg != '0) begin
               cnt_next = cnt_reg - 1'b1;
            end else begin
               state_next = GAP;
               cnt_next   = GAP_LOAD;
            end
         end
         GAP: begin
            if (cnt_reg != '0) begin
               cnt_next = cnt_reg - 1'b1;
               push     = tck;
            end else if (pend_reg != '0) begin
               // Queued tick restarts; a simultaneous new tick takes its place in the queue.
               state_next = HOLD;
               cnt_next   = HOLD_LOAD;
               pop        = 1'b1;
               push       = tck;
            end else if (tck) begin
               state_next = HOLD;
               cnt_next   = HOLD_LOAD;
            end else begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
            cnt_next   = '0;
         end
      endcase
   end

   always_comb begin
      pend_next = pend_reg;
      ovf_next  = ovf_reg;
      if (push && !pop) begin
         if (pend_reg == PEND_MAX) begin
            ovf_next = 1'b1;
         end else begin
            pend_next = pend_reg + 1'b1;
         end
      end else if (pop && !push) begin
         pend_next = pend_reg - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         pend_reg  <= '0;
         ovf_reg   <= 1'b0;
         lvl_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         pend_reg  <= pend_next;
         ovf_reg   <= ovf_next;
         lvl_reg   <= (state_next == HOLD);
      end
   end

   assign lvl      = lvl_reg;
   assign busy     = (state_reg != IDLE) || (pend_reg != '0);
   assign pending  = pend_reg;
   assign overflow = ovf_reg;

endmodule
